arp_tx_sched: RTL and testbench
===============================

# arp_tx_sched

ARP transmit scheduler for the SGMII Ethernet link test path. It sits in the `gmii_rx_clk` domain between the ARP protocol engine (`arp_tx_en`/`arp_tx_type`/`arp_rx_done`/`arp_rx_type`/`tx_done`) and its triggers: the user key, incoming ARP requests, and a periodic refresh timer. It keeps at most one ARP frame in flight and gives replies priority over requests. It also retries unanswered requests with a timeout and reports whether the peer MAC is resolved.

## Interface
Parameters:
- `REPLY_TIMEOUT`, 125_000_000 — cycles to wait for an ARP reply after a request has been sent (1 s at 125 MHz).
- `MAX_RETRY`, 3 — number of re-sends after the first request before declaring failure.
- `REFRESH_CYC`, 1_250_000_000 — cycles between automatic re-requests while resolved (10 s).
- `TX_WDOG`, 4096 — maximum cycles from `arp_tx_en` to `tx_done`.

Ports:
- `clk` in 1 — `gmii_rx_clk`, 125 MHz.
- `sys_rst_n` in 1 — asynchronous, active-low reset.
- `touch_key` in 1 — asynchronous level; a rising edge requests ARP resolution.
- `arp_rx_done` in 1 — one-cycle pulse: a valid ARP frame was received.
- `arp_rx_type` in 1 — qualified by `arp_rx_done`; 0 = request, 1 = reply.
- `tx_done` in 1 — one-cycle pulse: the ARP engine finished the current frame.
- `arp_tx_en` out 1 — one-cycle start pulse to the ARP engine.
- `arp_tx_type` out 1 — 0 = request, 1 = reply; valid while `arp_tx_en` = 1 and held until the next `arp_tx_en`.
- `resolved` out 1 — peer MAC is known.
- `arp_fail` out 1 — one-cycle pulse when retries are exhausted.
- `tx_wdog_err` out 1 — one-cycle pulse when `tx_done` does not arrive in time.
- `busy` out 1 — high in every state except IDLE.

## Operation
- States:
  - IDLE — no frame in flight, no request outstanding.
  - ISSUE — drive the start pulse for one cycle.
  - TX_BUSY — wait for `tx_done`.
  - WAIT_REPLY — request sent, waiting for the peer's reply.
- Pending flags (single bit each, so repeated events merge):
  - `reply_pend` is set by `arp_rx_done & ~arp_rx_type`.
  - `req_pend` is set by a key rising edge or by refresh-timer expiry.
- IDLE: if `reply_pend` → ISSUE as a reply; else if `req_pend` → ISSUE as a request.
- ISSUE: assert `arp_tx_en` and set `arp_tx_type` for the chosen kind, clear that kind's pending flag, latch the kind, then go to TX_BUSY.
- TX_BUSY:
  - On `tx_done`: a request → WAIT_REPLY with the reply timer cleared; a reply → return to the state it was issued from (IDLE or WAIT_REPLY).
  - If the watchdog reaches `TX_WDOG` cycles: pulse `tx_wdog_err`, clear `retry_cnt`, go to IDLE.
- WAIT_REPLY:
  - `arp_rx_done & arp_rx_type`: set `resolved`, clear `retry_cnt` and the refresh timer, go to IDLE.
  - `reply_pend`: go to ISSUE as a reply. The reply timer freezes until the state returns to WAIT_REPLY.
  - Timer reaches `REPLY_TIMEOUT-1` with `retry_cnt < MAX_RETRY`: increment `retry_cnt`, go to ISSUE as a request.
  - Timer reaches `REPLY_TIMEOUT-1` with `retry_cnt == MAX_RETRY`: pulse `arp_fail`, clear `resolved` and `retry_cnt`, go to IDLE.
- A key edge or refresh expiry while a request is outstanding (request in TX_BUSY, or WAIT_REPLY) is dropped.
- An ARP reply received outside WAIT_REPLY is ignored.
- The refresh timer counts only while `resolved` = 1 and the state is IDLE. It sets `req_pend` at `REFRESH_CYC-1`, then wraps to 0. `resolved` stays high during the refresh unless the refresh ends in `arp_fail`.
- Counter widths: `$clog2(param+1)` bits. No counter wraps except the refresh timer.

## Timing
- All outputs are registered. Reset values: every output is 0, state = IDLE, all flags and counters are 0.
- Assertion of `sys_rst_n` at any time aborts an in-flight frame and returns to reset values. The ARP engine is reset by the same event.
- Reply latency: with the state in IDLE, `arp_rx_done` (request) in cycle N gives `arp_tx_en` high in cycle N+2.
- Key latency: a 2-FF synchronizer plus edge detect adds 3 cycles, so a `touch_key` rise before edge N gives `arp_tx_en` in cycle N+5 when in IDLE.
- `arp_tx_en` is never asserted between an `arp_tx_en` pulse and the matching `tx_done` or watchdog expiry.
- If `arp_rx_done` coincides with a state transition, the event is still captured.
- If `tx_done` and watchdog expiry fall in the same cycle, `tx_done` wins.

## Structure
- Package `arp_sched_pkg`: state enum, `ARP_REQ` = 1'b0, `ARP_REPLY` = 1'b1.
- Sub-module `sync_edge`: 2-FF synchronizer plus rising-edge pulse, used for `touch_key`.
- Everything else stays in `arp_tx_sched`.

## Test plan
- Reset, then key pulse; reply arrives 1000 cycles after `tx_done` → one request (`arp_tx_type` = 0), `resolved` = 1, `retry_cnt` = 0.
- Key pulse with no reply, `REPLY_TIMEOUT` = 100, `MAX_RETRY` = 3 → 4 requests spaced 100 cycles + TX time, then `arp_fail` pulse, `resolved` = 0.
- ARP request received during WAIT_REPLY → reply sent next (`arp_tx_type` = 1); reply timer frozen during the reply, then resumes from its prior count.
- ARP request and key edge in the same cycle from IDLE → reply first, then request; exactly two `arp_tx_en` pulses.
- `tx_done` withheld, `TX_WDOG` = 50 → `tx_wdog_err` 50 cycles after `arp_tx_en`, state IDLE; later `sys_rst_n` low mid-WAIT_REPLY → all outputs 0 asynchronously.
- `resolved` = 1, `REFRESH_CYC` = 200 → automatic request after 200 idle cycles; no reply → `arp_fail` and `resolved` falls.

Source files
------------

// File: rtl/arp_sched_pkg.sv
// Shared types and constants for the ARP transmit scheduler.
package arp_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_ISSUE      = 2'd1,
    ST_TX_BUSY    = 2'd2,
    ST_WAIT_REPLY = 2'd3
  } arp_state_e;

  localparam logic ARP_REQ   = 1'b0;
  localparam logic ARP_REPLY = 1'b1;

  // Bits needed to hold 0..n, never less than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous level, followed by a
// registered single-cycle pulse on each rising edge.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o
);

  logic meta_q, sync_q, prev_q, rise_q;

  // Synchronize, keep a delayed copy, and register the edge pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_q <= sync_q & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/arp_tx_sched.sv
// ARP transmit scheduler: one frame in flight, replies before requests,
// request retry with reply timeout, periodic refresh while resolved.
module arp_tx_sched
  import arp_sched_pkg::*;
#(
  parameter int unsigned REPLY_TIMEOUT = 125_000_000,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned REFRESH_CYC   = 1_250_000_000,
  parameter int unsigned TX_WDOG       = 4096
) (
  input  logic clk,
  input  logic sys_rst_n,
  input  logic touch_key,
  input  logic arp_rx_done,
  input  logic arp_rx_type,
  input  logic tx_done,
  output logic arp_tx_en,
  output logic arp_tx_type,
  output logic resolved,
  output logic arp_fail,
  output logic tx_wdog_err,
  output logic busy
);

  localparam int unsigned RT_W = cnt_w(REPLY_TIMEOUT);
  localparam int unsigned RC_W = cnt_w(MAX_RETRY);
  localparam int unsigned RF_W = cnt_w(REFRESH_CYC);
  localparam int unsigned WD_W = cnt_w(TX_WDOG);

  localparam logic [RT_W-1:0] RT_LAST = RT_W'(REPLY_TIMEOUT - 1);
  localparam logic [RC_W-1:0] RC_MAX  = RC_W'(MAX_RETRY);
  localparam logic [RF_W-1:0] RF_LAST = RF_W'(REFRESH_CYC - 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TX_WDOG - 1);

  arp_state_e      state_q, state_d;
  logic            kind_q, kind_d;
  logic            ret_wait_q, ret_wait_d;
  logic            reply_pend_q, reply_pend_d;
  logic            req_pend_q, req_pend_d;
  logic [RT_W-1:0] rtmr_q, rtmr_d;
  logic [RC_W-1:0] retry_q, retry_d;
  logic [RF_W-1:0] rfsh_q, rfsh_d;
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            tx_en_q, tx_en_d;
  logic            tx_type_q, tx_type_d;
  logic            resolved_q, resolved_d;
  logic            fail_q, fail_d;
  logic            wdog_err_q, wdog_err_d;
  logic            busy_q, busy_d;

  logic key_rise;
  logic rx_req, rx_rep;
  logic refresh_hit;
  logic clr_reply, clr_req;
  logic req_outstanding;

  sync_edge u_key_sync (
    .clk    (clk),
    .rst_n  (sys_rst_n),
    .d_i    (touch_key),
    .rise_o (key_rise)
  );

  // Scheduler next-state, counters and registered-output decisions.
  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    ret_wait_d  = ret_wait_q;
    rtmr_d      = rtmr_q;
    retry_d     = retry_q;
    rfsh_d      = rfsh_q;
    wdog_d      = wdog_q;
    tx_type_d   = tx_type_q;
    resolved_d  = resolved_q;
    fail_d      = 1'b0;
    wdog_err_d  = 1'b0;
    refresh_hit = 1'b0;
    clr_reply   = 1'b0;
    clr_req     = 1'b0;
    rx_req      = arp_rx_done & ~arp_rx_type;
    rx_rep      = arp_rx_done & arp_rx_type;

    case (state_q)
      ST_IDLE: begin
        if (resolved_q) begin
          if (rfsh_q == RF_LAST) begin
            rfsh_d      = '0;
            refresh_hit = 1'b1;
          end else begin
            rfsh_d = rfsh_q + 1'b1;
          end
        end
        if (reply_pend_q) begin
          state_d    = ST_ISSUE;
          kind_d     = ARP_REPLY;
          ret_wait_d = 1'b0;
        end else if (req_pend_q) begin
          state_d    = ST_ISSUE;
          kind_d     = ARP_REQ;
          ret_wait_d = 1'b0;
        end
      end

      ST_ISSUE: begin
        state_d = ST_TX_BUSY;
        wdog_d  = wdog_q + 1'b1;
        if (kind_q == ARP_REPLY) clr_reply = 1'b1;
        else                     clr_req   = 1'b1;
      end

      ST_TX_BUSY: begin
        wdog_d = wdog_q + 1'b1;
        if (tx_done) begin
          if (kind_q == ARP_REQ) begin
            state_d = ST_WAIT_REPLY;
            rtmr_d  = '0;
          end else begin
            state_d = ret_wait_q ? ST_WAIT_REPLY : ST_IDLE;
          end
        end else if (wdog_q == WD_LAST) begin
          wdog_err_d = 1'b1;
          retry_d    = '0;
          state_d    = ST_IDLE;
        end
      end

      ST_WAIT_REPLY: begin
        if (rx_rep) begin
          resolved_d = 1'b1;
          retry_d    = '0;
          rfsh_d     = '0;
          state_d    = ST_IDLE;
        end else if (reply_pend_q) begin
          // Timer is left untouched here so the wait resumes where it stopped.
          state_d    = ST_ISSUE;
          kind_d     = ARP_REPLY;
          ret_wait_d = 1'b1;
        end else if (rtmr_q == RT_LAST) begin
          if (retry_q < RC_MAX) begin
            retry_d    = retry_q + 1'b1;
            state_d    = ST_ISSUE;
            kind_d     = ARP_REQ;
            ret_wait_d = 1'b0;
          end else begin
            fail_d     = 1'b1;
            resolved_d = 1'b0;
            retry_d    = '0;
            state_d    = ST_IDLE;
          end
        end else begin
          rtmr_d = rtmr_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Start of a frame: arm the watchdog and present the frame kind.
    if (state_d == ST_ISSUE && state_q != ST_ISSUE) begin
      wdog_d    = '0;
      tx_type_d = kind_d;
    end

    // A request is outstanding from its issue until the reply wait ends,
    // including any reply squeezed in while waiting.
    req_outstanding = (state_q == ST_WAIT_REPLY) ||
                      (((state_q == ST_ISSUE) || (state_q == ST_TX_BUSY)) &&
                       ((kind_q == ARP_REQ) || ret_wait_q));

    reply_pend_d = (reply_pend_q & ~clr_reply) | rx_req;
    req_pend_d   = (req_pend_q & ~clr_req) |
                   ((key_rise | refresh_hit) & ~req_outstanding);

    tx_en_d = (state_d == ST_ISSUE);
    busy_d  = (state_d != ST_IDLE);
  end

  // State, pending flags, counters and registered outputs.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= ST_IDLE;
      kind_q       <= ARP_REQ;
      ret_wait_q   <= 1'b0;
      reply_pend_q <= 1'b0;
      req_pend_q   <= 1'b0;
      rtmr_q       <= '0;
      retry_q      <= '0;
      rfsh_q       <= '0;
      wdog_q       <= '0;
      tx_en_q      <= 1'b0;
      tx_type_q    <= 1'b0;
      resolved_q   <= 1'b0;
      fail_q       <= 1'b0;
      wdog_err_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      kind_q       <= kind_d;
      ret_wait_q   <= ret_wait_d;
      reply_pend_q <= reply_pend_d;
      req_pend_q   <= req_pend_d;
      rtmr_q       <= rtmr_d;
      retry_q      <= retry_d;
      rfsh_q       <= rfsh_d;
      wdog_q       <= wdog_d;
      tx_en_q      <= tx_en_d;
      tx_type_q    <= tx_type_d;
      resolved_q   <= resolved_d;
      fail_q       <= fail_d;
      wdog_err_q   <= wdog_err_d;
      busy_q       <= busy_d;
    end
  end

  assign arp_tx_en   = tx_en_q;
  assign arp_tx_type = tx_type_q;
  assign resolved    = resolved_q;
  assign arp_fail    = fail_q;
  assign tx_wdog_err = wdog_err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_arp_tx_sched.sv
// Self-checking bench for arp_tx_sched with a small ARP engine model.
module tb_arp_tx_sched;
  import arp_sched_pkg::*;

  localparam int RT = 100;
  localparam int MR = 3;
  localparam int RF = 200;
  localparam int WD = 50;

  logic clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic touch_key = 1'b0;
  logic arp_rx_done = 1'b0;
  logic arp_rx_type = 1'b0;
  logic tx_done = 1'b0;
  logic arp_tx_en, arp_tx_type, resolved, arp_fail, tx_wdog_err, busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  bit eng_en  = 1'b1;
  int eng_lat = 0;
  int txq_cyc[$];
  bit txq_type[$];
  int last_done = -1;
  int done_n = 0;
  int fail_n = 0, fail_cyc = -1;
  int wdog_n = 0, wdog_cyc = -1;
  bit inflight = 1'b0;

  arp_tx_sched #(
    .REPLY_TIMEOUT (RT),
    .MAX_RETRY     (MR),
    .REFRESH_CYC   (RF),
    .TX_WDOG       (WD)
  ) dut (
    .clk         (clk),
    .sys_rst_n   (sys_rst_n),
    .touch_key   (touch_key),
    .arp_rx_done (arp_rx_done),
    .arp_rx_type (arp_rx_type),
    .tx_done     (tx_done),
    .arp_tx_en   (arp_tx_en),
    .arp_tx_type (arp_tx_type),
    .resolved    (resolved),
    .arp_fail    (arp_fail),
    .tx_wdog_err (tx_wdog_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ARP engine: log each start pulse, answer with tx_done after a latency.
  always begin
    @(negedge clk);
    if (sys_rst_n && arp_tx_en) begin
      txq_cyc.push_back(cyc);
      txq_type.push_back(arp_tx_type);
      if (eng_en) begin
        repeat ((eng_lat != 0) ? eng_lat : $urandom_range(4, 12)) @(negedge clk);
        tx_done   = 1'b1;
        last_done = cyc;
        done_n++;
        @(negedge clk);
        tx_done = 1'b0;
      end
    end
  end

  // Record single-cycle status pulses.
  always @(negedge clk) begin
    if (arp_fail) begin
      fail_n++;
      fail_cyc = cyc;
    end
    if (tx_wdog_err) begin
      wdog_n++;
      wdog_cyc = cyc;
    end
  end

  // At most one frame in flight between a start pulse and its completion.
  always @(posedge clk) begin
    if (!sys_rst_n) begin
      inflight = 1'b0;
    end else begin
      if (arp_tx_en) begin
        n_cmp++;
        if (inflight) begin
          n_err++;
          $display("FAIL one_in_flight: arp_tx_en=1 while a frame is in flight (cycle %0d), required no start", cyc);
        end
        inflight = 1'b1;
      end
      if (tx_done || tx_wdog_err) inflight = 1'b0;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL time_limit: simulation still running at %0t, required finished", $time);
    $fatal(1, "time limit");
  end

  task automatic wait_tx(input int limit, output int c, output bit t, output bit ok);
    ok = 1'b0;
    c  = -1;
    t  = 1'b0;
    for (int i = 0; i <= limit; i++) begin
      if (txq_cyc.size() != 0) begin
        c  = txq_cyc.pop_front();
        t  = txq_type.pop_front();
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_done(input int target, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i <= limit; i++) begin
      if (done_n >= target) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic pulse_rx(input logic typ, output int rc);
    rc          = cyc;
    arp_rx_done = 1'b1;
    arp_rx_type = typ;
    @(negedge clk);
    arp_rx_done = 1'b0;
    arp_rx_type = 1'b0;
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    repeat (3) @(negedge clk);
    txq_cyc.delete();
    txq_type.delete();
    sys_rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({arp_tx_en, arp_tx_type, resolved, arp_fail, tx_wdog_err, busy} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b required 000000",
               {arp_tx_en, arp_tx_type, resolved, arp_fail, tx_wdog_err, busy});
    end
    do_reset();
    repeat (20) @(negedge clk);
    n_cmp++;
    if (txq_cyc.size() != 0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: got %0d starts busy=%b required 0 starts busy=0", txq_cyc.size(), busy);
    end
  endtask

  task automatic test_reply_latency();
    int rc, c, tgt;
    bit t, ok;
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(3, 20)) @(negedge clk);
      tgt = done_n + 1;
      pulse_rx(ARP_REQ, rc);
      wait_tx(20, c, t, ok);
      n_cmp++;
      if (!ok || c != rc + 2 || t !== ARP_REPLY) begin
        n_err++;
        $display("FAIL reply_latency: got start cycle %0d type %b required cycle %0d type 1", c, t, rc + 2);
      end
      wait_done(tgt, 40, ok);
      repeat (3) @(negedge clk);
      n_cmp++;
      if (!ok || busy !== 1'b0 || resolved !== 1'b0 || txq_cyc.size() != 0) begin
        n_err++;
        $display("FAIL reply_return_idle: got busy=%b resolved=%b extra=%0d required 0 0 0",
                 busy, resolved, txq_cyc.size());
      end
    end
  endtask

  task automatic test_key_retry_fail();
    int kc, c, d, tgt, f0;
    bit t, ok;
    tgt = done_n;
    f0  = fail_n;
    touch_key = 1'b1;
    kc = cyc;
    repeat (8) @(negedge clk);
    touch_key = 1'b0;
    wait_tx(30, c, t, ok);
    n_cmp++;
    if (!ok || c != kc + 5 || t !== ARP_REQ) begin
      n_err++;
      $display("FAIL key_latency: got start cycle %0d type %b required cycle %0d type 0", c, t, kc + 5);
    end
    for (int i = 0; i < MR; i++) begin
      tgt++;
      wait_done(tgt, 40, ok);
      d = last_done;
      wait_tx(RT + 40, c, t, ok);
      n_cmp++;
      if (!ok || c != d + RT + 1 || t !== ARP_REQ) begin
        n_err++;
        $display("FAIL retry_%0d: got start cycle %0d type %b required cycle %0d type 0", i + 1, c, t, d + RT + 1);
      end
    end
    tgt++;
    wait_done(tgt, 40, ok);
    d = last_done;
    for (int i = 0; i < RT + 20 && fail_n == f0; i++) @(negedge clk);
    n_cmp++;
    if (fail_n != f0 + 1 || fail_cyc != d + RT + 1) begin
      n_err++;
      $display("FAIL retry_exhausted: got %0d pulses at cycle %0d required 1 at cycle %0d",
               fail_n - f0, fail_cyc, d + RT + 1);
    end
    repeat (20) @(negedge clk);
    n_cmp++;
    if (resolved !== 1'b0 || busy !== 1'b0 || txq_cyc.size() != 0 || fail_n != f0 + 1) begin
      n_err++;
      $display("FAIL after_fail: got resolved=%b busy=%b extra=%0d required 0 0 0",
               resolved, busy, txq_cyc.size());
    end
  endtask

  // Leaves the peer resolved; returns the cycle the reply was received.
  task automatic test_reply_and_key(output int rr);
    int kc, rc, c1, c2, tgt;
    bit t1, t2, ok;
    tgt = done_n;
    touch_key = 1'b1;
    kc = cyc;
    repeat (3) @(negedge clk);
    pulse_rx(ARP_REQ, rc);
    repeat (4) @(negedge clk);
    touch_key = 1'b0;
    wait_tx(30, c1, t1, ok);
    n_cmp++;
    if (!ok || c1 != kc + 5 || t1 !== ARP_REPLY) begin
      n_err++;
      $display("FAIL both_first: got cycle %0d type %b required cycle %0d type 1", c1, t1, kc + 5);
    end
    tgt++;
    wait_done(tgt, 40, ok);
    wait_tx(40, c2, t2, ok);
    n_cmp++;
    if (!ok || c2 != last_done + 2 || t2 !== ARP_REQ) begin
      n_err++;
      $display("FAIL both_second: got cycle %0d type %b required cycle %0d type 0", c2, t2, last_done + 2);
    end
    tgt++;
    wait_done(tgt, 40, ok);
    repeat ($urandom_range(5, 50)) @(negedge clk);
    pulse_rx(ARP_REPLY, rr);
    n_cmp++;
    if (resolved !== 1'b1 || busy !== 1'b0 || txq_cyc.size() != 0) begin
      n_err++;
      $display("FAIL resolve: got resolved=%b busy=%b extra=%0d required 1 0 0", resolved, busy, txq_cyc.size());
    end
  endtask

  task automatic test_refresh_fail(input int rr);
    int c, d, tgt, f0;
    bit t, ok;
    tgt = done_n;
    f0  = fail_n;
    wait_tx(RF + 30, c, t, ok);
    n_cmp++;
    if (!ok || c != rr + RF + 2 || t !== ARP_REQ || resolved !== 1'b1) begin
      n_err++;
      $display("FAIL refresh_start: got cycle %0d type %b resolved=%b required cycle %0d type 0 resolved=1",
               c, t, resolved, rr + RF + 2);
    end
    for (int i = 0; i < MR; i++) begin
      tgt++;
      wait_done(tgt, 40, ok);
      d = last_done;
      wait_tx(RT + 40, c, t, ok);
      n_cmp++;
      if (!ok || c != d + RT + 1 || t !== ARP_REQ || resolved !== 1'b1) begin
        n_err++;
        $display("FAIL refresh_retry_%0d: got cycle %0d resolved=%b required cycle %0d resolved=1",
                 i + 1, c, resolved, d + RT + 1);
      end
    end
    tgt++;
    wait_done(tgt, 40, ok);
    d = last_done;
    for (int i = 0; i < RT + 20 && fail_n == f0; i++) @(negedge clk);
    n_cmp++;
    if (fail_n != f0 + 1 || fail_cyc != d + RT + 1 || resolved !== 1'b0) begin
      n_err++;
      $display("FAIL refresh_fail: got pulses=%0d cycle %0d resolved=%b required 1 cycle %0d resolved=0",
               fail_n - f0, fail_cyc, resolved, d + RT + 1);
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reply_during_wait();
    int kc, c, w, rc, tgt, exp_c, rr;
    bit t, ok;
    tgt = done_n;
    touch_key = 1'b1;
    kc = cyc;
    repeat (8) @(negedge clk);
    touch_key = 1'b0;
    wait_tx(30, c, t, ok);
    tgt++;
    wait_done(tgt, 40, ok);
    w = last_done + 1;
    while (cyc < w + int'($urandom_range(10, 60))) @(negedge clk);
    pulse_rx(ARP_REQ, rc);
    wait_tx(20, c, t, ok);
    n_cmp++;
    if (!ok || c != rc + 2 || t !== ARP_REPLY) begin
      n_err++;
      $display("FAIL wait_reply_preempt: got cycle %0d type %b required cycle %0d type 1", c, t, rc + 2);
    end
    tgt++;
    wait_done(tgt, 40, ok);
    // Timer held (rc+1-w) counts when the reply was taken; it resumes from there.
    exp_c = last_done + 1 + RT - (rc + 1 - w);
    wait_tx(RT + 40, c, t, ok);
    n_cmp++;
    if (!ok || c != exp_c || t !== ARP_REQ) begin
      n_err++;
      $display("FAIL timer_frozen: got retry cycle %0d type %b required cycle %0d type 0", c, t, exp_c);
    end
    tgt++;
    wait_done(tgt, 40, ok);
    repeat (5) @(negedge clk);
    pulse_rx(ARP_REPLY, rr);
    n_cmp++;
    if (resolved !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL resolve_after_preempt: got resolved=%b busy=%b required 1 0", resolved, busy);
    end
  endtask

  task automatic test_wdog_and_reset();
    int c, w0, tgt, rr;
    bit t, ok;
    do_reset();
    eng_en = 1'b0;
    w0 = wdog_n;
    touch_key = 1'b1;
    repeat (8) @(negedge clk);
    touch_key = 1'b0;
    wait_tx(30, c, t, ok);
    for (int i = 0; i < WD + 20 && wdog_n == w0; i++) @(negedge clk);
    n_cmp++;
    if (!ok || wdog_n != w0 + 1 || wdog_cyc != c + WD || busy !== 1'b0) begin
      n_err++;
      $display("FAIL tx_watchdog: got pulses=%0d cycle %0d busy=%b required 1 cycle %0d busy=0",
               wdog_n - w0, wdog_cyc, busy, c + WD);
    end
    repeat (10) @(negedge clk);
    n_cmp++;
    if (txq_cyc.size() != 0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL wdog_idle: got extra=%0d busy=%b required 0 0", txq_cyc.size(), busy);
    end

    // tx_done in the very cycle the watchdog would expire.
    eng_en  = 1'b1;
    eng_lat = WD - 1;
    tgt = done_n + 1;
    touch_key = 1'b1;
    repeat (8) @(negedge clk);
    touch_key = 1'b0;
    wait_tx(30, c, t, ok);
    wait_done(tgt, WD + 10, ok);
    repeat (5) @(negedge clk);
    n_cmp++;
    if (!ok || last_done != c + WD - 1 || wdog_n != w0 + 1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL done_beats_wdog: got wdog pulses=%0d busy=%b required 0 busy=1", wdog_n - w0 - 1, busy);
    end
    eng_lat = 0;
    pulse_rx(ARP_REPLY, rr);
    tgt = done_n + 1;
    touch_key = 1'b1;
    repeat (8) @(negedge clk);
    touch_key = 1'b0;
    wait_tx(30, c, t, ok);
    wait_done(tgt, 40, ok);
    repeat (20) @(negedge clk);
    n_cmp++;
    if (resolved !== 1'b1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset_state: got resolved=%b busy=%b required 1 1", resolved, busy);
    end
    @(posedge clk);
    #3;
    sys_rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({arp_tx_en, arp_tx_type, resolved, arp_fail, tx_wdog_err, busy} !== 6'b0) begin
      n_err++;
      $display("FAIL async_reset: got %b required 000000",
               {arp_tx_en, arp_tx_type, resolved, arp_fail, tx_wdog_err, busy});
    end
    repeat (3) @(negedge clk);
    txq_cyc.delete();
    txq_type.delete();
    sys_rst_n = 1'b1;
    repeat (30) @(negedge clk);
    n_cmp++;
    if (txq_cyc.size() != 0 || busy !== 1'b0 || resolved !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_idle: got extra=%0d busy=%b resolved=%b required 0 0 0",
               txq_cyc.size(), busy, resolved);
    end
  endtask

  initial begin
    int rr;
    test_reset();
    test_reply_latency();
    test_key_retry_fail();
    test_reply_and_key(rr);
    test_refresh_fail(rr);
    test_reply_during_wait();
    test_wdog_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
